// File: rtl/snake_pkg.sv
// Shared constants for the snake game datapath: counting direction encoding
// and the default grid coordinate width.
package snake_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int GRID_W = 5;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: one history flop plus an AND gate. The history presets
// to 1 so a level already high when reset releases is not seen as an edge.
module rise_detect (
  input  logic clock,
  input  logic reset_n,
  input  logic step,
  output logic take
);

  logic step_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values and simulation matches the synthesized netlist.
  always_ff @(posedge clock) begin
    if (!reset_n) step_q <= 1'b1;
    else          step_q <= step;
  end

  assign take = step & ~step_q;

endmodule

// File: rtl/wrap_counter.sv
// WIDTH-bit modulo counter over 0..max with run-time up/down direction,
// synchronous clear/load, optional rising-edge step qualification and a
// one-cycle wrap strobe.
module wrap_counter
  import snake_pkg::*;
#(
  parameter int WIDTH       = GRID_W,
  parameter int EDGE_STEP   = 1,
  parameter int RESET_VALUE = 0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] max,
  input  logic             step,
  input  logic             dir,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             at_max,
  output logic             at_zero
);

  localparam logic [WIDTH-1:0] RESET_CNT = RESET_VALUE[WIDTH-1:0];

  logic take;

  generate
    if (EDGE_STEP != 0) begin : g_edge
      rise_detect u_rise_detect (
        .clock   (clock),
        .reset_n (reset_n),
        .step    (step),
        .take    (take)
      );
    end else begin : g_level
      assign take = step;
    end
  endgenerate

  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] next_count;
  logic             next_wrap;

  assign load_clamped = (load_value > max) ? max : load_value;

  // Relational compares (not equality) let a step recover a count stranded
  // above a max that shrank underneath it.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    next_count = count;
    next_wrap  = 1'b0;
    if (dir == DIR_UP) begin
      if (count >= max) begin
        next_count = '0;
        next_wrap  = 1'b1;
      end else begin
        next_count = count + 1'b1;
      end
    end else begin
      if (count == '0 || count > max) begin
        next_count = max;
        next_wrap  = 1'b1;
      end else begin
        next_count = count - 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count <= RESET_CNT;
      wrap  <= 1'b0;
    end else if (clear) begin
      count <= RESET_CNT;
      wrap  <= 1'b0;
    end else if (load) begin
      count <= load_clamped;
      wrap  <= 1'b0;
    end else if (take) begin
      count <= next_count;
      wrap  <= next_wrap;
    end else begin
      wrap  <= 1'b0;
    end
  end

  assign at_max  = (count == max);
  assign at_zero = (count == '0);

endmodule

// File: tb/tb_wrap_counter.sv
// Directed bench for wrap_counter: an edge-qualified instance (RESET_VALUE=0)
// and a level-qualified instance (RESET_VALUE=3) sharing control inputs.
module tb_wrap_counter;

  localparam int W = 5;

  logic         clock = 1'b0;
  logic         reset_n;
  logic [W-1:0] max;
  logic         step, step_l, dir, clear, load;
  logic [W-1:0] load_value;

  logic [W-1:0] count_e, count_l;
  logic         wrap_e, wrap_l, at_max_e, at_max_l, at_zero_e, at_zero_l;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  wrap_counter #(.WIDTH(W), .EDGE_STEP(1), .RESET_VALUE(0)) dut_e (
    .clock(clock), .reset_n(reset_n), .max(max), .step(step), .dir(dir),
    .clear(clear), .load(load), .load_value(load_value),
    .count(count_e), .wrap(wrap_e), .at_max(at_max_e), .at_zero(at_zero_e)
  );

  wrap_counter #(.WIDTH(W), .EDGE_STEP(0), .RESET_VALUE(3)) dut_l (
    .clock(clock), .reset_n(reset_n), .max(max), .step(step_l), .dir(dir),
    .clear(clear), .load(load), .load_value(load_value),
    .count(count_l), .wrap(wrap_l), .at_max(at_max_l), .at_zero(at_zero_l)
  );

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; max = 5'd5; step = 1'b0; step_l = 1'b0; dir = 1'b0;
    clear = 1'b0; load = 1'b0; load_value = '0;
    tick(2);
    n_cmp++; if (count_e !== 5'd0) begin n_bad++; $display("FAIL reset_count_e: got %0d want 0", count_e); end
    n_cmp++; if (wrap_e !== 1'b0) begin n_bad++; $display("FAIL reset_wrap_e: got %0b want 0", wrap_e); end
    n_cmp++; if (at_zero_e !== 1'b1) begin n_bad++; $display("FAIL reset_at_zero_e: got %0b want 1", at_zero_e); end
    n_cmp++; if (at_max_e !== 1'b0) begin n_bad++; $display("FAIL reset_at_max_e: got %0b want 0", at_max_e); end
    n_cmp++; if (count_l !== 5'd3) begin n_bad++; $display("FAIL reset_count_l: got %0d want 3", count_l); end
    reset_n = 1'b1;
    tick(1);
    n_cmp++; if (count_e !== 5'd0) begin n_bad++; $display("FAIL reset_idle_hold: got %0d want 0", count_e); end
  endtask

  task automatic test_wrap_up;
    logic [W-1:0] exp_c;
    max = 5'd5; dir = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      exp_c = (i == 6) ? 5'd0 : 5'(i);
      step = 1'b1; tick(1);
      n_cmp++; if (count_e !== exp_c) begin n_bad++; $display("FAIL wrap_up_count[%0d]: got %0d want %0d", i, count_e, exp_c); end
      n_cmp++; if (wrap_e !== (i == 6)) begin n_bad++; $display("FAIL wrap_up_wrap[%0d]: got %0b want %0b", i, wrap_e, (i == 6)); end
      n_cmp++; if (at_max_e !== (exp_c == 5'd5)) begin n_bad++; $display("FAIL wrap_up_at_max[%0d]: got %0b want %0b", i, at_max_e, (exp_c == 5'd5)); end
      step = 1'b0; tick(1);
      n_cmp++; if (wrap_e !== 1'b0) begin n_bad++; $display("FAIL wrap_up_wrap_low[%0d]: got %0b want 0", i, wrap_e); end
    end
  endtask

  task automatic test_down_underflow;
    max = 5'd5; dir = 1'b1;
    step = 1'b1; tick(1);
    n_cmp++; if (count_e !== 5'd5) begin n_bad++; $display("FAIL down_uf_count: got %0d want 5", count_e); end
    n_cmp++; if (wrap_e !== 1'b1) begin n_bad++; $display("FAIL down_uf_wrap: got %0b want 1", wrap_e); end
    step = 1'b0; tick(1);
    n_cmp++; if (wrap_e !== 1'b0) begin n_bad++; $display("FAIL down_uf_wrap_pulse: got %0b want 0", wrap_e); end
    step = 1'b1; tick(1);
    n_cmp++; if (count_e !== 5'd4) begin n_bad++; $display("FAIL down_next_count: got %0d want 4", count_e); end
    n_cmp++; if (wrap_e !== 1'b0) begin n_bad++; $display("FAIL down_next_wrap: got %0b want 0", wrap_e); end
    step = 1'b0; tick(1);
  endtask

  task automatic test_edge_vs_level;
    clear = 1'b1; tick(1); clear = 1'b0;
    n_cmp++; if (count_l !== 5'd3) begin n_bad++; $display("FAIL clear_count_l: got %0d want 3", count_l); end
    max = 5'd5; dir = 1'b0;
    step = 1'b1; step_l = 1'b1;
    tick(10);
    step = 1'b0; step_l = 1'b0;
    tick(1);
    // edge: exactly one advance; level: 3 + 10 mod 6 = 1
    n_cmp++; if (count_e !== 5'd1) begin n_bad++; $display("FAIL edge_held_count: got %0d want 1", count_e); end
    n_cmp++; if (count_l !== 5'd1) begin n_bad++; $display("FAIL level_held_count: got %0d want 1", count_l); end
  endtask

  task automatic test_back_to_back;
    max = 5'd0; dir = 1'b0; step_l = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      n_cmp++; if (count_l !== 5'd0) begin n_bad++; $display("FAIL b2b_count[%0d]: got %0d want 0", i, count_l); end
      n_cmp++; if (wrap_l !== 1'b1) begin n_bad++; $display("FAIL b2b_wrap[%0d]: got %0b want 1", i, wrap_l); end
    end
    step_l = 1'b0; tick(1);
    n_cmp++; if (wrap_l !== 1'b0) begin n_bad++; $display("FAIL b2b_wrap_end: got %0b want 0", wrap_l); end
  endtask

  task automatic test_load_priority;
    max = 5'd7; dir = 1'b0;
    load_value = 5'd20; load = 1'b1; tick(1); load = 1'b0;
    n_cmp++; if (count_e !== 5'd7) begin n_bad++; $display("FAIL load_clamp: got %0d want 7", count_e); end
    n_cmp++; if (at_max_e !== 1'b1) begin n_bad++; $display("FAIL load_at_max: got %0b want 1", at_max_e); end
    // A step alone here would wrap 7 -> 0; load must win and suppress wrap.
    load_value = 5'd2; load = 1'b1; step = 1'b1; tick(1);
    load = 1'b0; step = 1'b0;
    n_cmp++; if (count_e !== 5'd2) begin n_bad++; $display("FAIL load_over_step_count: got %0d want 2", count_e); end
    n_cmp++; if (wrap_e !== 1'b0) begin n_bad++; $display("FAIL load_over_step_wrap: got %0b want 0", wrap_e); end
    tick(1);
    load_value = 5'd6; clear = 1'b1; load = 1'b1; tick(1);
    clear = 1'b0; load = 1'b0;
    n_cmp++; if (count_e !== 5'd0) begin n_bad++; $display("FAIL clear_over_load_e: got %0d want 0", count_e); end
    n_cmp++; if (count_l !== 5'd3) begin n_bad++; $display("FAIL clear_over_load_l: got %0d want 3", count_l); end
  endtask

  task automatic test_max_shrink;
    max = 5'd15; load_value = 5'd9; load = 1'b1; tick(1); load = 1'b0;
    max = 5'd4; tick(2);
    n_cmp++; if (count_e !== 5'd9) begin n_bad++; $display("FAIL shrink_hold: got %0d want 9", count_e); end
    n_cmp++; if (at_max_e !== 1'b0) begin n_bad++; $display("FAIL shrink_at_max: got %0b want 0", at_max_e); end
    dir = 1'b0; step = 1'b1; tick(1);
    n_cmp++; if (count_e !== 5'd0) begin n_bad++; $display("FAIL shrink_up_count: got %0d want 0", count_e); end
    n_cmp++; if (wrap_e !== 1'b1) begin n_bad++; $display("FAIL shrink_up_wrap: got %0b want 1", wrap_e); end
    step = 1'b0; tick(1);
    max = 5'd15; load = 1'b1; tick(1); load = 1'b0; max = 5'd4;
    dir = 1'b1; step = 1'b1; tick(1);
    n_cmp++; if (count_e !== 5'd4) begin n_bad++; $display("FAIL shrink_down_count: got %0d want 4", count_e); end
    n_cmp++; if (wrap_e !== 1'b1) begin n_bad++; $display("FAIL shrink_down_wrap: got %0b want 1", wrap_e); end
    step = 1'b0; tick(1);
  endtask

  task automatic test_full_range;
    max = 5'd31; load_value = 5'd31; load = 1'b1; tick(1); load = 1'b0;
    dir = 1'b0; step = 1'b1; tick(1);
    n_cmp++; if (count_e !== 5'd0) begin n_bad++; $display("FAIL full_up_count: got %0d want 0", count_e); end
    n_cmp++; if (wrap_e !== 1'b1) begin n_bad++; $display("FAIL full_up_wrap: got %0b want 1", wrap_e); end
    step = 1'b0; tick(1);
    dir = 1'b1; step = 1'b1; tick(1);
    n_cmp++; if (count_e !== 5'd31) begin n_bad++; $display("FAIL full_down_count: got %0d want 31", count_e); end
    n_cmp++; if (wrap_e !== 1'b1) begin n_bad++; $display("FAIL full_down_wrap: got %0b want 1", wrap_e); end
    step = 1'b0; tick(1);
  endtask

  task automatic test_reset_step_held;
    max = 5'd7; dir = 1'b0;
    load_value = 5'd3; load = 1'b1; step = 1'b1; tick(1); load = 1'b0;
    n_cmp++; if (count_e !== 5'd3) begin n_bad++; $display("FAIL pre_reset_count: got %0d want 3", count_e); end
    reset_n = 1'b0; tick(2);
    n_cmp++; if (count_e !== 5'd0) begin n_bad++; $display("FAIL step_reset_count: got %0d want 0", count_e); end
    n_cmp++; if (wrap_e !== 1'b0) begin n_bad++; $display("FAIL step_reset_wrap: got %0b want 0", wrap_e); end
    reset_n = 1'b1; tick(2);
    n_cmp++; if (count_e !== 5'd0) begin n_bad++; $display("FAIL held_after_reset: got %0d want 0", count_e); end
    step = 1'b0; tick(1);
    step = 1'b1; tick(1);
    n_cmp++; if (count_e !== 5'd1) begin n_bad++; $display("FAIL new_edge_count: got %0d want 1", count_e); end
    n_cmp++; if (wrap_e !== 1'b0) begin n_bad++; $display("FAIL new_edge_wrap: got %0b want 0", wrap_e); end
    step = 1'b0; tick(1);
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_down_underflow();
    test_edge_vs_level();
    test_back_to_back();
    test_load_priority();
    test_max_shrink();
    test_full_range();
    test_reset_step_held();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
